usr_shift_ctl: RTL and testbench
================================

# usr_shift_ctl

Sequencer for a chain of USR4 universal shift registers. It accepts one command per handshake (load, or shift left/right by a count with a selectable fill mode). It drives the chain's shared SEL code and serial inputs S0/S3 cycle by cycle, then pulses DONE. It sits between the microcode-level datapath control and any USR4-built register (single 4-bit slice or a cascaded word) so that multi-bit shifts no longer need per-cycle microcode steering.

## Interface
- CNTW, default 6: width of the shift count; maximum shift is 2^CNTW-1.
- CLK  in  1  clock; all state changes on posedge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  command strobe; sampled on posedge while BUSY=0.
- OP  in  2  00 load, 01 shift right (toward higher bit index, S0 enters bit 0), 10 shift left (toward bit 0, S3 enters last bit), 11 no-op.
- FILL  in  2  00 zeros, 01 ones, 10 rotate, 11 arithmetic.
- COUNT  in  CNTW  number of shift cycles; ignored for load and no-op.
- QMSB  in  1  bit 0 of the USR4 chain (current Q).
- QLSB  in  1  last bit of the USR4 chain (current Q).
- SEL  out  2  to USR4 SEL: 00 LOAD, 01 S0in, 10 S3in, 11 HOLD.
- S0  out  1  serial input to chain bit 0.
- S3  out  1  serial input to chain last bit.
- BUSY  out  1  command in progress.
- DONE  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, SHIFT, FINISH.
- IDLE outputs: SEL=11, S0=S3=0, BUSY=0, DONE=0.
- A command is accepted when START=1 and BUSY=0 (state IDLE or FINISH). At acceptance OP, FILL and COUNT are latched. Later input changes have no effect until the next acceptance.
- OP=00 goes to LOAD for exactly one cycle with SEL=00, then to FINISH.
- OP=01 or 10 with COUNT≠0 goes to SHIFT. SEL is 01 (right) or 10 (left) for exactly COUNT cycles. A down-counter loads COUNT and decrements once per SHIFT cycle. SHIFT exits to FINISH when the counter reaches 1.
- OP=11, or a shift with COUNT=0, goes directly to FINISH. No LOAD or shift cycle occurs.
- FINISH lasts one cycle: DONE=1, BUSY=0, SEL=11. It returns to IDLE, or starts the next command if START=1.
- BUSY=1 exactly in LOAD and SHIFT. START while BUSY=1 is ignored and is not queued.
- Fill in SHIFT is combinational from the latched FILL and the live QMSB/QLSB:
  - right shift: zeros S0=0; ones S0=1; rotate S0=QLSB; arithmetic S0=QMSB (sign replicate).
  - left shift: zeros S3=0; ones S3=1; rotate S3=QMSB; arithmetic S3=0.
- The unused serial input is 0. Outside SHIFT, S0=S3=0.
- SEL, BUSY and DONE are registered with no combinational path from START.

## Timing
- Reset (RESET=1 at a posedge): state IDLE, SEL=11, S0=S3=0, BUSY=0, DONE=0, counter=0. Reset overrides START on the same edge.
- Reset during LOAD or SHIFT aborts the command at that edge: SEL=11 afterwards and no DONE pulse. Shifts already clocked into the USR4s are not undone.
- Command accepted at edge k:
  - Load: SEL=00 between edges k and k+1, so the chain loads at k+1. DONE is high between k+1 and k+2.
  - Shift by N: SEL is the shift code between edges k and k+N, so the chain shifts at k+1..k+N. DONE is high between k+N and k+N+1.
  - No-op or COUNT=0: DONE is high between edges k and k+1. The chain is untouched.
- Back-to-back: START=1 during the DONE cycle is accepted. The DONE cycle then also carries the first SEL code of the new command, so there is no idle gap.
- Maximum COUNT (2^CNTW-1) performs that many shifts. The counter does not wrap.

## Test plan
- Load: single USR4, D=1010, START with OP=00. Required: SEL=00 for one cycle, Q=1010 at the next edge, DONE one cycle later, BUSY high for exactly 1 cycle.
- Right shift, zero fill: from Q=1010, OP=01, FILL=00, COUNT=1. Required: Q=0101, DONE after 1 shift cycle. Then COUNT=2 with FILL=01 gives Q=1101.
- Left rotate: from Q=1011, OP=10, FILL=10, COUNT=3. Required: Q steps 0111, 1110, 1101. SEL=10 for exactly 3 cycles. DONE in the 4th cycle after acceptance.
- Arithmetic right: from Q=1000, OP=01, FILL=11, COUNT=2. Required: Q=1100 then 1110. An arithmetic left by 1 on 1110 gives 1100.
- Edge cases:
  - COUNT=0 shift: SEL stays 11, Q unchanged, DONE the cycle after acceptance.
  - START while BUSY: ignored.
  - START during DONE: accepted with no gap.
- Reset mid-shift: rotate with COUNT=5, RESET asserted on the 3rd shift cycle. Required: exactly 2 shifts applied, SEL=11, BUSY=0 after the reset edge, and no DONE pulse.

Source files
------------

// File: rtl/usr_shift_ctl.sv
// usr_shift_ctl: cycle-by-cycle sequencer for a chain of USR4 universal
// shift registers. It accepts one load/shift/no-op command per handshake and
// drives the shared SEL code plus the serial inputs S0/S3, then pulses DONE.
module usr_shift_ctl #(
    parameter int CNTW = 6
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [1:0]      OP,
    input  logic [1:0]      FILL,
    input  logic [CNTW-1:0] COUNT,
    input  logic            QMSB,
    input  logic            QLSB,
    output logic [1:0]      SEL,
    output logic            S0,
    output logic            S3,
    output logic            BUSY,
    output logic            DONE
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    localparam logic [1:0] FILL_ZERO  = 2'b00;
    localparam logic [1:0] FILL_ONES  = 2'b01;
    localparam logic [1:0] FILL_ROT   = 2'b10;
    localparam logic [1:0] FILL_ARITH = 2'b11;

    localparam logic [1:0] SEL_LOAD = 2'b00;
    localparam logic [1:0] SEL_S0IN = 2'b01;
    localparam logic [1:0] SEL_S3IN = 2'b10;
    localparam logic [1:0] SEL_HOLD = 2'b11;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [1:0]      fill_q, fill_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [1:0]      sel_q, sel_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Next-state, command latching, shift counter and registered outputs.
    // SEL/BUSY/DONE are decoded from the next state so they are flops that
    // line up exactly with the state they describe.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE, ST_FINISH: begin
                state_d = ST_IDLE;
                if (START) begin
                    op_d   = OP;
                    fill_d = FILL;
                    case (OP)
                        OP_LOAD: state_d = ST_LOAD;
                        OP_SHR, OP_SHL: begin
                            if (COUNT != '0) begin
                                state_d = ST_SHIFT;
                                cnt_d   = COUNT;
                            end else begin
                                state_d = ST_FINISH;
                            end
                        end
                        OP_NOP:  state_d = ST_FINISH;
                        default: state_d = ST_FINISH;
                    endcase
                end
            end
            ST_LOAD: begin
                state_d = ST_FINISH;
            end
            ST_SHIFT: begin
                // The counter holds the number of shift cycles still to run,
                // including the current one; the last one exits on value 1.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNTW'(1)) begin
                    state_d = ST_FINISH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        sel_d  = SEL_HOLD;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            ST_LOAD: begin
                sel_d  = SEL_LOAD;
                busy_d = 1'b1;
            end
            ST_SHIFT: begin
                sel_d  = (op_d == OP_SHR) ? SEL_S0IN : SEL_S3IN;
                busy_d = 1'b1;
            end
            ST_FINISH: begin
                done_d = 1'b1;
            end
            default: begin
                sel_d = SEL_HOLD;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset; a reset
    // mid-command simply drops back to IDLE without a DONE pulse.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            fill_q  <= FILL_ZERO;
            cnt_q   <= '0;
            sel_q   <= SEL_HOLD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Serial fill: combinational from the latched fill mode and live chain
    // end bits, so rotate/arithmetic track Q as it moves each cycle.
    always_comb begin
        S0 = 1'b0;
        S3 = 1'b0;
        if (state_q == ST_SHIFT) begin
            if (op_q == OP_SHR) begin
                case (fill_q)
                    FILL_ZERO:  S0 = 1'b0;
                    FILL_ONES:  S0 = 1'b1;
                    FILL_ROT:   S0 = QLSB;
                    FILL_ARITH: S0 = QMSB;
                    default:    S0 = 1'b0;
                endcase
            end else begin
                case (fill_q)
                    FILL_ZERO:  S3 = 1'b0;
                    FILL_ONES:  S3 = 1'b1;
                    FILL_ROT:   S3 = QMSB;
                    FILL_ARITH: S3 = 1'b0;
                    default:    S3 = 1'b0;
                endcase
            end
        end
    end

    assign SEL  = sel_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_usr_shift_ctl.sv
// Directed bench for usr_shift_ctl driving a single 4-bit USR4 slice model.
// Chain values are written bit 0 first (logic [0:3]), so 4'b1010 means
// bit0=1, bit1=0, bit2=1, bit3=0.
module tb_usr_shift_ctl;

    localparam int CNTW = 6;

    logic            CLK = 1'b0;
    logic            RESET;
    logic            START;
    logic [1:0]      OP;
    logic [1:0]      FILL;
    logic [CNTW-1:0] COUNT;
    logic            QMSB;
    logic            QLSB;
    logic [1:0]      SEL;
    logic            S0;
    logic            S3;
    logic            BUSY;
    logic            DONE;

    logic [0:3] chain = 4'b0000;
    logic [0:3] d_in  = 4'b0000;

    int tests  = 0;
    int failed = 0;

    usr_shift_ctl #(.CNTW(CNTW)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .OP(OP), .FILL(FILL),
        .COUNT(COUNT), .QMSB(QMSB), .QLSB(QLSB), .SEL(SEL), .S0(S0),
        .S3(S3), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // USR4 slice: 00 load, 01 shift toward higher index (S0 in),
    // 10 shift toward bit 0 (S3 in), 11 hold.
    always @(posedge CLK) begin
        case (SEL)
            2'b00:   chain <= d_in;
            2'b01:   chain <= {S0, chain[0:2]};
            2'b10:   chain <= {chain[1:3], S3};
            default: chain <= chain;
        endcase
    end

    assign QMSB = chain[0];
    assign QLSB = chain[3];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] fill, input logic [CNTW-1:0] cnt);
        START = 1'b1; OP = op; FILL = fill; COUNT = cnt;
        tick();
        START = 1'b0;
    endtask

    task automatic preload(input logic [0:3] v);
        d_in = v;
        issue(2'b00, 2'b00, '0);
        tick();
        tick();
    endtask

    task automatic test_reset();
        RESET = 1'b1; START = 1'b1; OP = 2'b00; FILL = 2'b00; COUNT = 6'd3;
        tick();
        tests++; if (SEL !== 2'b11) begin failed++; $display("FAIL reset_sel got %b want 11", SEL); end
        tests++; if (BUSY !== 1'b0) begin failed++; $display("FAIL reset_busy got %b want 0", BUSY); end
        tests++; if (DONE !== 1'b0) begin failed++; $display("FAIL reset_done got %b want 0", DONE); end
        tests++; if ({S0, S3} !== 2'b00) begin failed++; $display("FAIL reset_s0s3 got %b want 00", {S0, S3}); end
        START = 1'b0;
        tick();
        RESET = 1'b0;
        tick();
        tests++; if ({SEL, BUSY, DONE} !== 4'b1100) begin failed++; $display("FAIL idle_outputs got %b want 1100", {SEL, BUSY, DONE}); end
    endtask

    task automatic test_load();
        d_in = 4'b1010;
        issue(2'b00, 2'b00, 6'd5);
        tests++; if (SEL !== 2'b00) begin failed++; $display("FAIL load_sel got %b want 00", SEL); end
        tests++; if (BUSY !== 1'b1) begin failed++; $display("FAIL load_busy got %b want 1", BUSY); end
        tick();
        tests++; if (chain !== 4'b1010) begin failed++; $display("FAIL load_q got %b want 1010", chain); end
        tests++; if ({DONE, BUSY, SEL} !== 4'b1011) begin failed++; $display("FAIL load_finish got %b want 1011", {DONE, BUSY, SEL}); end
        tick();
        tests++; if (DONE !== 1'b0) begin failed++; $display("FAIL load_done_pulse got %b want 0", DONE); end
    endtask

    task automatic test_shift_right();
        issue(2'b01, 2'b00, 6'd1);
        tests++; if ({SEL, S0} !== 3'b010) begin failed++; $display("FAIL shr0_sel_s0 got %b want 010", {SEL, S0}); end
        tick();
        tests++; if (chain !== 4'b0101) begin failed++; $display("FAIL shr0_q got %b want 0101", chain); end
        tests++; if (DONE !== 1'b1) begin failed++; $display("FAIL shr0_done got %b want 1", DONE); end
        tick();
        issue(2'b01, 2'b01, 6'd2);
        tests++; if ({SEL, S0} !== 3'b011) begin failed++; $display("FAIL shr1_sel_s0 got %b want 011", {SEL, S0}); end
        tick();
        tests++; if ({chain, DONE} !== 5'b10100) begin failed++; $display("FAIL shr1_step1 got %b want 10100", {chain, DONE}); end
        tick();
        tests++; if ({chain, DONE} !== 5'b11011) begin failed++; $display("FAIL shr1_step2 got %b want 11011", {chain, DONE}); end
        tick();
    endtask

    task automatic test_left_rotate();
        logic [0:3] exp_q [3] = '{4'b0111, 4'b1110, 4'b1101};
        preload(4'b1011);
        issue(2'b10, 2'b10, 6'd3);
        tests++; if (S3 !== 1'b1) begin failed++; $display("FAIL rotl_s3 got %b want 1", S3); end
        for (int i = 0; i < 3; i++) begin
            tests++; if ({SEL, DONE} !== 3'b100) begin failed++; $display("FAIL rotl_sel%0d got %b want 100", i, {SEL, DONE}); end
            tick();
            tests++; if (chain !== exp_q[i]) begin failed++; $display("FAIL rotl_q%0d got %b want %b", i, chain, exp_q[i]); end
        end
        tests++; if ({SEL, DONE} !== 3'b111) begin failed++; $display("FAIL rotl_finish got %b want 111", {SEL, DONE}); end
        tick();
    endtask

    task automatic test_arith();
        preload(4'b1000);
        issue(2'b01, 2'b11, 6'd2);
        tests++; if (S0 !== 1'b1) begin failed++; $display("FAIL asr_s0 got %b want 1", S0); end
        tick();
        tests++; if (chain !== 4'b1100) begin failed++; $display("FAIL asr_q1 got %b want 1100", chain); end
        tick();
        tests++; if ({chain, DONE} !== 5'b11101) begin failed++; $display("FAIL asr_q2 got %b want 11101", {chain, DONE}); end
        tick();
        issue(2'b10, 2'b11, 6'd1);
        tests++; if ({SEL, S3} !== 3'b100) begin failed++; $display("FAIL asl_sel_s3 got %b want 100", {SEL, S3}); end
        tick();
        tests++; if ({chain, DONE} !== 5'b11001) begin failed++; $display("FAIL asl_q got %b want 11001", {chain, DONE}); end
        tick();
    endtask

    task automatic test_count_zero();
        issue(2'b01, 2'b01, 6'd0);
        tests++; if ({SEL, BUSY, DONE} !== 4'b1101) begin failed++; $display("FAIL cnt0_outputs got %b want 1101", {SEL, BUSY, DONE}); end
        tick();
        tests++; if ({chain, DONE} !== 5'b11000) begin failed++; $display("FAIL cnt0_q got %b want 11000", {chain, DONE}); end
        issue(2'b11, 2'b00, 6'd7);
        tests++; if ({SEL, BUSY, DONE} !== 4'b1101) begin failed++; $display("FAIL nop_outputs got %b want 1101", {SEL, BUSY, DONE}); end
        tick();
        tests++; if ({chain, DONE} !== 5'b11000) begin failed++; $display("FAIL nop_q got %b want 11000", {chain, DONE}); end
    endtask

    task automatic test_busy_ignore();
        d_in = 4'b0000;
        issue(2'b01, 2'b00, 6'd3);
        START = 1'b1; OP = 2'b00; FILL = 2'b01; COUNT = 6'd1;
        tick();
        START = 1'b0;
        tests++; if ({SEL, BUSY} !== 3'b011) begin failed++; $display("FAIL busy_start_sel got %b want 011", {SEL, BUSY}); end
        tick();
        tick();
        tests++; if ({chain, DONE} !== 5'b00011) begin failed++; $display("FAIL busy_start_q got %b want 00011", {chain, DONE}); end
        tick();
        tests++; if ({SEL, DONE} !== 3'b110) begin failed++; $display("FAIL busy_not_queued got %b want 110", {SEL, DONE}); end
    endtask

    task automatic test_back_to_back();
        d_in = 4'b1010;
        issue(2'b00, 2'b00, '0);
        tick();
        tests++; if (DONE !== 1'b1) begin failed++; $display("FAIL b2b_first_done got %b want 1", DONE); end
        issue(2'b01, 2'b01, 6'd1);
        tests++; if ({SEL, BUSY, DONE} !== 4'b0110) begin failed++; $display("FAIL b2b_accept got %b want 0110", {SEL, BUSY, DONE}); end
        tests++; if (chain !== 4'b1010) begin failed++; $display("FAIL b2b_loaded got %b want 1010", chain); end
        tick();
        tests++; if ({chain, DONE} !== 5'b11011) begin failed++; $display("FAIL b2b_second got %b want 11011", {chain, DONE}); end
        tick();
    endtask

    task automatic test_max_count();
        int n_shift;
        int n_wait;
        preload(4'b1010);
        issue(2'b01, 2'b10, 6'd63);
        n_shift = 0;
        n_wait  = 0;
        while (DONE !== 1'b1 && n_wait < 200) begin
            if (SEL === 2'b01) n_shift++;
            tick();
            n_wait++;
        end
        tests++; if (DONE !== 1'b1) begin failed++; $display("FAIL max_done_timeout got %b want 1", DONE); end
        tests++; if (n_shift !== 63) begin failed++; $display("FAIL max_shift_cycles got %0d want 63", n_shift); end
        tests++; if (chain !== 4'b0101) begin failed++; $display("FAIL max_q got %b want 0101", chain); end
        tick();
    endtask

    task automatic test_reset_mid();
        int done_seen;
        preload(4'b1011);
        issue(2'b10, 2'b10, 6'd5);
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        tests++; if ({SEL, BUSY, DONE} !== 4'b1100) begin failed++; $display("FAIL rstmid_outputs got %b want 1100", {SEL, BUSY, DONE}); end
        tests++; if (chain !== 4'b1110) begin failed++; $display("FAIL rstmid_q got %b want 1110", chain); end
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (DONE === 1'b1) done_seen++;
            tick();
        end
        tests++; if (done_seen !== 0) begin failed++; $display("FAIL rstmid_no_done got %0d want 0", done_seen); end
        tests++; if (chain !== 4'b1110) begin failed++; $display("FAIL rstmid_q_hold got %b want 1110", chain); end
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; OP = 2'b11; FILL = 2'b00; COUNT = '0;
        test_reset();
        test_load();
        test_shift_right();
        test_left_rotate();
        test_arith();
        test_count_zero();
        test_busy_ignore();
        test_back_to_back();
        test_max_count();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
